// File: rtl/div_pkg.sv
// Shared types and widths for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH  = 8;
  localparam int unsigned ITER_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    HOLD = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sub9.sv
// Combinational (WIDTH+1)-bit trial subtractor: difference plus sign of a - b.
module div_sub9 import div_pkg::*; #(
  parameter int unsigned W = DIV_WIDTH + 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff_c,
  output logic         o_neg_c
);

  always_comb begin
    o_diff_c = i_a - i_b;
    o_neg_c  = o_diff_c[W-1];
  end

endmodule

// File: rtl/seq_divider_8.sv
// 8-bit unsigned restoring divider: divisor held from switches, one quotient bit per clock.
module seq_divider_8 import div_pkg::*; (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DIV_WIDTH-1:0] SW_i,
  input  logic                 LoadB_i,
  input  logic                 Run_i,
  output logic [DIV_WIDTH-1:0] Divisor_o,
  output logic [DIV_WIDTH-1:0] Quot_o,
  output logic [DIV_WIDTH-1:0] Rem_o,
  output logic                 Busy_o,
  output logic                 Done_o,
  output logic                 DivZero_o
);

  localparam int unsigned WIDTH = DIV_WIDTH;

  div_state_t            r_state;
  div_state_t            w_state_nxt;
  logic [WIDTH-1:0]      r_b;
  logic [WIDTH-1:0]      w_b_nxt;
  logic [WIDTH-1:0]      r_q;
  logic [WIDTH-1:0]      w_q_nxt;
  // Partial remainder stays below the divisor, so its ninth bit is always zero
  // and only the low WIDTH bits are kept.
  logic [WIDTH-1:0]      r_r;
  logic [WIDTH-1:0]      w_r_nxt;
  logic [ITER_CNT_W-1:0] r_cnt;
  logic [ITER_CNT_W-1:0] w_cnt_nxt;
  logic                  r_dz;
  logic                  w_dz_nxt;
  logic                  r_busy;
  logic                  r_done;

  logic [WIDTH:0]        w_rs;
  logic [WIDTH:0]        w_trial;
  logic                  w_neg;

  // Shifted remainder brings in the next dividend bit.
  assign w_rs = {r_r, r_q[WIDTH-1]};

  div_sub9 #(.W(WIDTH + 1)) u_sub (
    .i_a      (w_rs),
    .i_b      ({1'b0, r_b}),
    .o_diff_c (w_trial),
    .o_neg_c  (w_neg)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_b     <= w_b_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dz    <= w_dz_nxt;
      r_busy  <= (w_state_nxt == ITER);
      r_done  <= (w_state_nxt == HOLD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_cnt_nxt   = r_cnt;
    w_dz_nxt    = r_dz;
    case (r_state)
      IDLE: begin
        // Run takes priority over a simultaneous divisor load.
        if (Run_i) begin
          w_q_nxt     = SW_i;
          w_r_nxt     = '0;
          w_cnt_nxt   = '0;
          w_dz_nxt    = (r_b == '0);
          w_state_nxt = ITER;
        end else if (LoadB_i) begin
          w_b_nxt = SW_i;
        end
      end
      ITER: begin
        if (!w_neg) begin
          w_r_nxt = w_trial[WIDTH-1:0];
          w_q_nxt = {r_q[WIDTH-2:0], 1'b1};
        end else begin
          w_r_nxt = w_rs[WIDTH-1:0];
          w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt + ITER_CNT_W'(1);
        if (r_cnt == ITER_CNT_W'(WIDTH - 1)) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!Run_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign Divisor_o = r_b;
  assign Quot_o    = r_q;
  assign Rem_o     = r_r;
  assign Busy_o    = r_busy;
  assign Done_o    = r_done;
  assign DivZero_o = r_dz;

endmodule

// File: tb/tb_seq_divider_8.sv
// Self-checking bench for seq_divider_8: directed cases plus random operands vs. arithmetic model.
module tb_seq_divider_8;

  logic       Clk;
  logic       Reset;
  logic [7:0] SW_i;
  logic       LoadB_i;
  logic       Run_i;
  logic [7:0] Divisor_o;
  logic [7:0] Quot_o;
  logic [7:0] Rem_o;
  logic       Busy_o;
  logic       Done_o;
  logic       DivZero_o;

  int total;
  int bad;
  logic [7:0] exp_b;

  seq_divider_8 dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .SW_i      (SW_i),
    .LoadB_i   (LoadB_i),
    .Run_i     (Run_i),
    .Divisor_o (Divisor_o),
    .Quot_o    (Quot_o),
    .Rem_o     (Rem_o),
    .Busy_o    (Busy_o),
    .Done_o    (Done_o),
    .DivZero_o (DivZero_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {5'd0, Divisor_o, Quot_o, Rem_o, Busy_o, Done_o, DivZero_o};
  endfunction

  task automatic load_b(input logic [7:0] v);
    SW_i    = v;
    LoadB_i = 1'b1;
    step();
    LoadB_i = 1'b0;
    exp_b   = v;
    chk("load_b", 32'(Divisor_o), 32'(v));
  endtask

  // Full division: start, count busy cycles while disturbing SW/LoadB, check result, release.
  task automatic run_div(input logic [7:0] a, input bit disturb);
    logic [7:0] eq;
    logic [7:0] er;
    int n;
    eq = (exp_b == 8'd0) ? 8'hFF : 8'(a / exp_b);
    er = (exp_b == 8'd0) ? a     : 8'(a % exp_b);
    SW_i  = a;
    Run_i = 1'b1;
    step();
    chk("busy_start", 32'({Busy_o, Done_o}), 32'b10);
    n = 0;
    while (Busy_o && n < 20) begin
      if (disturb) begin
        SW_i    = 8'($urandom);
        LoadB_i = 1'b1;
      end
      n++;
      step();
    end
    LoadB_i = 1'b0;
    chk("busy_cycles", 32'(n), 32'd8);
    chk("done", 32'(Done_o), 32'd1);
    chk("divisor_stable", 32'(Divisor_o), 32'(exp_b));
    chk("quot", 32'(Quot_o), 32'(eq));
    chk("rem", 32'(Rem_o), 32'(er));
    chk("divzero", 32'(DivZero_o), 32'(exp_b == 8'd0));
    Run_i = 1'b0;
    step();
    chk("release_idle", 32'({Busy_o, Done_o}), 32'b00);
    chk("result_kept", 32'({Quot_o, Rem_o}), 32'({eq, er}));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_b   = 8'd0;
    Reset   = 1'b1;
    SW_i    = 8'd0;
    LoadB_i = 1'b0;
    Run_i   = 1'b0;
    #3;
    chk("reset_outs", all_outs(), 32'd0);
    step();
    Reset = 1'b0;
    step();

    // Basic divide 100 / 7.
    load_b(8'h07);
    run_div(8'h64, 1'b0);

    // Edge operands.
    load_b(8'hFF);
    run_div(8'hFE, 1'b0);
    run_div(8'hFF, 1'b0);
    load_b(8'h01);
    run_div(8'hA5, 1'b1);

    // Divide by zero, then a normal run clears the flag.
    load_b(8'h00);
    run_div(8'h5A, 1'b0);
    load_b(8'h03);
    run_div(8'h5A, 1'b0);

    // Run and LoadB together: Run wins, divisor untouched.
    SW_i    = 8'h09;
    LoadB_i = 1'b1;
    Run_i   = 1'b1;
    step();
    LoadB_i = 1'b0;
    chk("run_beats_load", 32'(Divisor_o), 32'h03);
    // Keep Run high: exactly one operation, Done stays high.
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 8) chk("hold_run_high", 32'({Busy_o, Done_o}), 32'b01);
    end
    chk("hold_quot", 32'(Quot_o), 32'h03);
    Run_i = 1'b0;
    step();
    chk("hold_release", 32'({Busy_o, Done_o}), 32'b00);

    // Asynchronous reset at the 4th iteration cycle.
    load_b(8'h37);
    SW_i  = 8'h80;
    Run_i = 1'b1;
    step();
    step();
    step();
    step();
    chk("mid_busy", 32'(Busy_o), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset_outs", all_outs(), 32'd0);
    Reset = 1'b0;
    Run_i = 1'b0;
    exp_b = 8'd0;
    step();
    chk("post_reset_idle", all_outs(), 32'd0);
    load_b(8'h05);
    run_div(8'h11, 1'b1);

    // Random operands, occasionally a zero divisor.
    for (int k = 0; k < 30; k++) begin
      load_b(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      run_div(8'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
